// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller that shares one 8-bit RAM port
// between data loads/stores and instruction fetches.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_read, mem_write        data load / store request from the mem stage
//   mem_write_type             0=none 1=sb 2=sh 3=sw
//   mem_addr, mem_wdata        data byte address, store data (LSB first)
//   mem_data, mem_done         assembled load word, data access complete
//   if_req, if_addr            instruction fetch request and address
//   if_inst, if_done           fetched instruction, fetch complete
//   ram_addr, ram_dout, ram_wr byte address, write byte, write strobe
//   ram_din                    read byte, valid one cycle after ram_addr
//   stall_req                  pipeline stall while a data access is pending
//
// Build option: define MEMCTRL_IO_SAFE_EN to make data reads whose
// mem_addr[17:16] is 2'b11 fetch a single byte (upper 24 bits read as 0).

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_write_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_data,
  output logic        mem_done,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        stall_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRD,
    S_DWR,
    S_IRD,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        fetch_q, fetch_d;
  logic        write_q, write_d;
  logic [31:0] mdata_q, mdata_d;
  logic [31:0] inst_q, inst_d;

  logic        wr_req;
  logic        acc_wr;
  logic        acc_rd;
  logic        acc_if;
  logic        acc_any;
  logic [2:0]  req_len;
  logic        last;
  logic [1:0]  cap_idx;
  logic [1:0]  lm1;
  logic [4:0]  shamt;
  logic [31:0] rd_word;

  // A store with type 0 is not a request at all.
  assign wr_req  = mem_write && (mem_write_type != 2'd0);
  assign acc_wr  = wr_req;
  assign acc_rd  = !wr_req && mem_read;
  assign acc_if  = !wr_req && !mem_read && if_req;
  assign acc_any = acc_wr || acc_rd || acc_if;

  always_comb begin
    req_len = 3'd4;
    if (acc_wr) begin
      case (mem_write_type)
        2'd1:    req_len = 3'd1;
        2'd2:    req_len = 3'd2;
        default: req_len = 3'd4;
      endcase
    end
`ifdef MEMCTRL_IO_SAFE_EN
    else if (acc_rd && (mem_addr[17:16] == 2'b11)) begin
      req_len = 3'd1;
    end
`else
`endif
  end

  assign last = (cnt_q == (len_q - 3'd1));

  // Byte k arrives while the counter already points at k+1.
  assign cap_idx = cnt_q[1:0] - 2'd1;

  // The final byte is still on ram_din in the done cycle, so it is
  // merged combinationally into the result at its lane (len-1).
  assign lm1     = len_q[1:0] - 2'd1;
  assign shamt   = {lm1, 3'b000};
  assign rd_word = acc_q | ({24'd0, ram_din} << shamt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          acc_wr:  state_d = S_DWR;
          acc_rd:  state_d = S_DRD;
          acc_if:  state_d = S_IRD;
          default: state_d = S_IDLE;
        endcase
      end
      S_DRD, S_DWR, S_IRD: begin
        if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      wdata_q <= '0;
      len_q   <= 3'd4;
      cnt_q   <= '0;
      acc_q   <= '0;
      fetch_q <= 1'b0;
      write_q <= 1'b0;
      mdata_q <= '0;
      inst_q  <= '0;
    end else begin
      base_q  <= base_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fetch_q <= fetch_d;
      write_q <= write_d;
      mdata_q <= mdata_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    base_d  = base_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    fetch_d = fetch_q;
    write_d = write_q;
    mdata_d = mdata_q;
    inst_d  = inst_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc_any) begin
          base_d  = acc_if ? if_addr : mem_addr;
          wdata_d = mem_wdata;
          len_d   = req_len;
          cnt_d   = '0;
          acc_d   = '0;
          fetch_d = acc_if;
          write_d = acc_wr;
        end
      end
      S_DRD, S_IRD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) begin
          acc_d[{cap_idx, 3'b000} +: 8] = ram_din;
        end
      end
      S_DWR: begin
        cnt_d = cnt_q + 3'd1;
      end
      S_DONE: begin
        cnt_d = '0;
        if (fetch_q) begin
          inst_d = rd_word;
        end else if (!write_q) begin
          mdata_d = rd_word;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    ram_addr = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    mem_done = 1'b0;
    if_done  = 1'b0;
    mem_data = mdata_q;
    if_inst  = inst_q;
    unique case (state_q)
      S_DRD, S_IRD: begin
        ram_addr = base_q + {29'd0, cnt_q};
      end
      S_DWR: begin
        ram_addr = base_q + {29'd0, cnt_q};
        ram_wr   = 1'b1;
        case (cnt_q[1:0])
          2'd0:    ram_dout = wdata_q[7:0];
          2'd1:    ram_dout = wdata_q[15:8];
          2'd2:    ram_dout = wdata_q[23:16];
          default: ram_dout = wdata_q[31:24];
        endcase
      end
      S_DONE: begin
        if (fetch_q) begin
          if_done = 1'b1;
          if_inst = rd_word;
        end else begin
          mem_done = 1'b1;
          if (!write_q) mem_data = rd_word;
        end
      end
      default: ;
    endcase
  end

  assign stall_req = (mem_read || wr_req) && !mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte-wide
// synchronous RAM model with hand-computed expectations.

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_write_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic        mem_done;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stall_req;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_type (mem_write_type),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data       (mem_data),
    .mem_done       (mem_done),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_inst        (if_inst),
    .if_done        (if_done),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_wr         (ram_wr),
    .ram_din        (ram_din),
    .stall_req      (stall_req)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:4095];
  logic        ld_en = 1'b0;
  logic [11:0] ld_a;
  logic [7:0]  ld_d;

  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    if (ld_en) ram[ld_a] <= ld_d;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  logic [31:0] a_log [0:15];
  logic [7:0]  d_log [0:15];
  logic        w_log [0:15];
  logic        s_log [0:15];
  int          md_t, id_t, n_md, n_id, n_wr, n_st;
  logic [31:0] md_val, id_val;

  // Cycle t=0 is the cycle in which the caller raised the request.
  task automatic run(input int n);
    logic dm, di;
    md_t = -1; id_t = -1;
    n_md = 0; n_id = 0; n_wr = 0; n_st = 0;
    md_val = '0; id_val = '0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      a_log[t] = ram_addr;
      d_log[t] = ram_dout;
      w_log[t] = ram_wr;
      s_log[t] = stall_req;
      if (ram_wr) n_wr++;
      if (stall_req) n_st++;
      if (mem_done) begin
        n_md++;
        if (md_t < 0) begin md_t = t; md_val = mem_data; end
      end
      if (if_done) begin
        n_id++;
        if (id_t < 0) begin id_t = t; id_val = if_inst; end
      end
      dm = mem_done;
      di = if_done;
      @(posedge clk);
      #1;
      if (dm) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_write_type = 2'd0;
      end
      if (di) if_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_write_type = 0;
    mem_addr = 0; mem_wdata = 0; if_req = 0; if_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    poke(12'h100, 8'h11); poke(12'h101, 8'h22);
    poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h202, 8'h5A);
    poke(12'h000, 8'h41); poke(12'h001, 8'h52);
    poke(12'h002, 8'h63); poke(12'h003, 8'h74);
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hB2);
    for (int i = 0; i < 4; i++) poke(12'h300 + 12'(i), 8'h00);

    // load word at 0x100
    mem_read = 1; mem_addr = 32'h100;
    run(9);
    chk("rd_done_t", md_t, 5);
    chk("rd_done_n", n_md, 1);
    chk("rd_data", md_val, 32'h44332211);
    chk("rd_stall_n", n_st, 5);
    chk("rd_stall_t4", {31'd0, s_log[4]}, 32'd1);
    chk("rd_stall_t5", {31'd0, s_log[5]}, 32'd0);
    chk("rd_addr1", a_log[1], 32'h100);
    chk("rd_addr4", a_log[4], 32'h103);
    chk("rd_nowr", n_wr, 0);
    chk("rd_hold", mem_data, 32'h44332211);

    // halfword store at 0x200
    mem_write = 1; mem_write_type = 2; mem_addr = 32'h200;
    mem_wdata = 32'hDEADBEEF;
    run(7);
    chk("sh_wr1", {31'd0, w_log[1]}, 32'd1);
    chk("sh_a1", a_log[1], 32'h200);
    chk("sh_d1", {24'd0, d_log[1]}, 32'hEF);
    chk("sh_a2", a_log[2], 32'h201);
    chk("sh_d2", {24'd0, d_log[2]}, 32'hBE);
    chk("sh_wr_n", n_wr, 2);
    chk("sh_done_t", md_t, 3);
    chk("sh_stall_n", n_st, 3);
    chk("sh_ram200", {24'd0, ram[12'h200]}, 32'hEF);
    chk("sh_ram201", {24'd0, ram[12'h201]}, 32'hBE);
    chk("sh_ram202", {24'd0, ram[12'h202]}, 32'h5A);

    // store and fetch raised together: store goes first
    if_req = 1; if_addr = 32'h0;
    mem_write = 1; mem_write_type = 3; mem_addr = 32'h10;
    mem_wdata = 32'h01020304;
    run(14);
    chk("pri_md_t", md_t, 5);
    chk("pri_wr_n", n_wr, 4);
    chk("pri_id_t", id_t, 11);
    chk("pri_id_n", n_id, 1);
    chk("pri_inst", id_val, 32'h74635241);
    chk("pri_ram10", {24'd0, ram[12'h010]}, 32'h04);
    chk("pri_ram13", {24'd0, ram[12'h013]}, 32'h01);

    // address wrap
    mem_read = 1; mem_addr = 32'hFFFFFFFE;
    run(8);
    chk("wrap_a1", a_log[1], 32'hFFFFFFFE);
    chk("wrap_a2", a_log[2], 32'hFFFFFFFF);
    chk("wrap_a3", a_log[3], 32'h0);
    chk("wrap_a4", a_log[4], 32'h1);
    chk("wrap_data", md_val, 32'h5241B2A1);

    // reset during T2 of a word store
    mem_write = 1; mem_write_type = 3; mem_addr = 32'h300;
    mem_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1; mem_write = 0; mem_write_type = 0;
    @(posedge clk);
    #1;
    rst = 0;
    run(6);
    chk("rstmid_wr_n", n_wr, 0);
    chk("rstmid_md_n", n_md, 0);
    chk("rstmid_ram300", {24'd0, ram[12'h300]}, 32'h0D);
    chk("rstmid_ram301", {24'd0, ram[12'h301]}, 32'hF0);
    chk("rstmid_ram302", {24'd0, ram[12'h302]}, 32'h00);
    chk("rstmid_ram303", {24'd0, ram[12'h303]}, 32'h00);

    // read in the I/O window 0x30000
    mem_read = 1; mem_addr = 32'h30000;
    run(8);
    chk("io_done_n", n_md, 1);
`ifdef MEMCTRL_IO_SAFE_EN
    chk("io_done_t", md_t, 2);
    chk("io_data", md_val, 32'h00000041);
`else
    chk("io_done_t", md_t, 5);
    chk("io_data", md_val, 32'h74635241);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
